// File: rtl/tron_pkg.sv
// Shared definitions for the Tron playfield grid: geometry defaults,
// cell encodings and the claim FSM state type.
package tron_pkg;

    localparam int DEF_GRID_W = 80;
    localparam int DEF_GRID_H = 60;
    localparam int DEF_ADDR_W = 13;
    localparam int DEF_CELL_W = 2;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_P1    = 2'd1;
    localparam logic [1:0] CELL_P2    = 2'd2;
    localparam logic [1:0] CELL_WALL  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } claim_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. The pointer remembers the winner of
// the last contended arbitration; an uncontended grant leaves it alone.
// After reset player 1 is favoured.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic i_req1,
    input  logic i_req2,
    input  logic i_take,
    output logic o_gnt1,
    output logic o_gnt2
);

    logic r_prefer2;

    // Combinational grant from live requests and the preference pointer.
    always_comb begin
        o_gnt1 = 1'b0;
        o_gnt2 = 1'b0;
        if (i_req1 && (!i_req2 || !r_prefer2)) begin
            o_gnt1 = 1'b1;
        end else if (i_req2) begin
            o_gnt2 = 1'b1;
        end else begin
            o_gnt1 = 1'b0;
        end
    end

    // Flip preference to the loser whenever both were asking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prefer2 <= 1'b0;
        end else if (i_take && i_req1 && i_req2) begin
            r_prefer2 <= o_gnt1;
        end else begin
            r_prefer2 <= r_prefer2;
        end
    end

endmodule

// File: rtl/grid_arbiter.sv
// Single-port grid RAM arbiter: display reads (fixed 3-cycle latency,
// never stalled) > clear engine > atomic player claim FSM.
// Optional build macro: GRID_CLEAR_EN enables the grid clear engine.
module grid_arbiter
    import tron_pkg::*;
#(
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CELL_W = DEF_CELL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [CELL_W-1:0] disp_data,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p2_req,
    input  logic [ADDR_W-1:0] p2_addr,
    output logic              p1_ack,
    output logic              p1_hit,
    output logic              p2_ack,
    output logic              p2_hit,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [CELL_W-1:0] mem_wdata,
    input  logic [CELL_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(GRID_W * GRID_H);
    localparam logic [CELL_W-1:0] C_EMPTY = CELL_W'(CELL_EMPTY);
    localparam logic [CELL_W-1:0] C_P1    = CELL_W'(CELL_P1);
    localparam logic [CELL_W-1:0] C_P2    = CELL_W'(CELL_P2);

    claim_state_t      r_state, w_next;
    logic              w_gnt1, w_gnt2, w_take, w_claim_go;
    logic              w_clr_block, w_clr_wr;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_slot_free;
    logic [ADDR_W-1:0] w_grant_addr, w_claim_addr, r_addr;
    logic              w_who_p2, r_p2;
    logic              w_rd_issue, w_wr_issue, w_ack_set, w_hit;
    logic              r_rd_inflight, r_wr_issued;
    logic              r_dv1, r_dv2;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .i_req1 (p1_req),
        .i_req2 (p2_req),
        .i_take (w_take),
        .o_gnt1 (w_gnt1),
        .o_gnt2 (w_gnt2)
    );

`ifdef GRID_CLEAR_EN
    logic              r_clr_busy, r_clr_done, r_clr_pend;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              w_clr_accept, w_clr_active;

    // Clear engine start/write decisions; a start arriving mid-claim waits in r_clr_pend.
    always_comb begin
        w_clr_accept = (r_state == ST_IDLE) && !r_clr_busy && (clr_start || r_clr_pend);
        w_clr_addr   = w_clr_accept ? {ADDR_W{1'b0}} : r_clr_addr;
        w_clr_active = w_clr_accept || (r_clr_busy && (r_clr_addr < CELLS_A));
        w_clr_wr     = w_clr_active && !disp_req;
        w_clr_block  = clr_start || r_clr_pend || r_clr_busy;
    end

    // Clear engine state: busy flag, address walker, pending start, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
            r_clr_pend <= 1'b0;
            r_clr_addr <= {ADDR_W{1'b0}};
        end else begin
            r_clr_done <= 1'b0;
            if (w_clr_accept) begin
                r_clr_busy <= 1'b1;
                r_clr_pend <= 1'b0;
            end else if (r_clr_busy && (r_clr_addr == CELLS_A)) begin
                r_clr_busy <= 1'b0;
                r_clr_done <= 1'b1;
            end else if (clr_start && !r_clr_busy) begin
                r_clr_pend <= 1'b1;
            end else begin
                r_clr_pend <= r_clr_pend;
            end
            if (w_clr_wr) begin
                r_clr_addr <= w_clr_addr + ADDR_W'(1);
            end else if (w_clr_accept) begin
                r_clr_addr <= {ADDR_W{1'b0}};
            end else begin
                r_clr_addr <= r_clr_addr;
            end
        end
    end

    assign clr_busy = r_clr_busy;
    assign clr_done = r_clr_done;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_start;
    assign w_clr_wr     = 1'b0;
    assign w_clr_addr   = {ADDR_W{1'b0}};
    assign w_clr_block  = 1'b0;
    assign clr_busy     = 1'b0;
    assign clr_done     = 1'b0;
`endif

    assign w_slot_free  = !disp_req && !w_clr_wr;
    assign w_claim_go   = (r_state == ST_IDLE) && !w_clr_block && (p1_req || p2_req);
    assign w_grant_addr = w_gnt1 ? p1_addr : p2_addr;
    assign w_who_p2     = (r_state == ST_IDLE) ? w_gnt2 : r_p2;
    assign w_claim_addr = (r_state == ST_IDLE) ? w_grant_addr : r_addr;

    // Claim FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Claim FSM next state and memory/ack decisions.
    always_comb begin
        w_next     = r_state;
        w_take     = 1'b0;
        w_rd_issue = 1'b0;
        w_wr_issue = 1'b0;
        w_ack_set  = 1'b0;
        w_hit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_claim_go) begin
                    w_take = 1'b1;
                    if (w_grant_addr >= CELLS_A) begin
                        w_ack_set = 1'b1;
                        w_hit     = 1'b1;
                        w_next    = ST_RESP;
                    end else if (w_slot_free) begin
                        w_rd_issue = 1'b1;
                        w_next     = ST_WAIT;
                    end else begin
                        w_next = ST_RD;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RD: begin
                if (w_slot_free) begin
                    w_rd_issue = 1'b1;
                    w_next     = ST_WAIT;
                end else begin
                    w_next = ST_RD;
                end
            end
            ST_WAIT: begin
                // First WAIT cycle is the read on the bus; data arrives the next.
                if (r_rd_inflight) begin
                    w_next = ST_WAIT;
                end else if (mem_rdata == C_EMPTY) begin
                    w_wr_issue = w_slot_free;
                    w_next     = ST_WR;
                end else begin
                    w_ack_set = 1'b1;
                    w_hit     = 1'b1;
                    w_next    = ST_RESP;
                end
            end
            ST_WR: begin
                if (r_wr_issued) begin
                    w_ack_set = 1'b1;
                    w_next    = ST_RESP;
                end else if (w_slot_free) begin
                    w_wr_issue = 1'b1;
                    w_next     = ST_WR;
                end else begin
                    w_next = ST_WR;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Claim context: granted player/address and read/write progress flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr        <= {ADDR_W{1'b0}};
            r_p2          <= 1'b0;
            r_rd_inflight <= 1'b0;
            r_wr_issued   <= 1'b0;
        end else begin
            if (w_take) begin
                r_addr <= w_grant_addr;
                r_p2   <= w_gnt2;
            end else begin
                r_addr <= r_addr;
                r_p2   <= r_p2;
            end
            r_rd_inflight <= w_rd_issue;
            if (w_wr_issue) begin
                r_wr_issued <= 1'b1;
            end else if (r_state != ST_WR) begin
                r_wr_issued <= 1'b0;
            end else begin
                r_wr_issued <= r_wr_issued;
            end
        end
    end

    // Registered ack/hit pulses for whichever player owns the claim.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_ack <= 1'b0;
            p1_hit <= 1'b0;
            p2_ack <= 1'b0;
            p2_hit <= 1'b0;
        end else begin
            p1_ack <= w_ack_set && !w_who_p2;
            p1_hit <= w_ack_set && !w_who_p2 && w_hit;
            p2_ack <= w_ack_set && w_who_p2;
            p2_hit <= w_ack_set && w_who_p2 && w_hit;
        end
    end

    // RAM port slot: display > clear > claim read > claim write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= {ADDR_W{1'b0}};
            mem_we    <= 1'b0;
            mem_wdata <= {CELL_W{1'b0}};
        end else if (disp_req) begin
            mem_addr  <= disp_addr;
            mem_we    <= 1'b0;
            mem_wdata <= {CELL_W{1'b0}};
        end else if (w_clr_wr) begin
            mem_addr  <= w_clr_addr;
            mem_we    <= 1'b1;
            mem_wdata <= C_EMPTY;
        end else if (w_rd_issue) begin
            mem_addr  <= w_claim_addr;
            mem_we    <= 1'b0;
            mem_wdata <= {CELL_W{1'b0}};
        end else if (w_wr_issue) begin
            mem_addr  <= r_addr;
            mem_we    <= 1'b1;
            mem_wdata <= r_p2 ? C_P2 : C_P1;
        end else begin
            mem_addr  <= mem_addr;
            mem_we    <= 1'b0;
            mem_wdata <= {CELL_W{1'b0}};
        end
    end

    // Display pipeline: address out, RAM data back, registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dv1      <= 1'b0;
            r_dv2      <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= {CELL_W{1'b0}};
        end else begin
            r_dv1      <= disp_req;
            r_dv2      <= r_dv1;
            disp_valid <= r_dv2;
            disp_data  <= r_dv2 ? mem_rdata : {CELL_W{1'b0}};
        end
    end

endmodule
